// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
//   Shared types and constants for the load/store unit: FSM state encoding,
//   RISC-V funct3 size/signedness codes for loads and stores, fault codes, and
//   the start-of-operation legality check.
// -----------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_DONE = 2'b11
    } lsu_state_e;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_ILLEGAL  = 2'b10,
        FAULT_TIMEOUT  = 2'b11
    } lsu_fault_e;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Access size lives in funct3[1:0] for both loads and stores.
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Classify an operation at start. Illegal encodings take priority over
    // misalignment, so an illegal op with a bad address reports illegal.
    function automatic lsu_fault_e op_check(input logic       is_load,
                                            input logic       is_store,
                                            input logic [2:0] funct3,
                                            input logic [1:0] addr_lo);
        logic illegal;
        logic misalign;
        illegal  = (is_load && is_store)
                || (is_load && (funct3 == 3'b011 || funct3 == 3'b110 ||
                                funct3 == 3'b111))
                || (is_store && (funct3 >= 3'b011));
        misalign = ((funct3[1:0] == SIZE_HALF) && addr_lo[0])
                || ((funct3[1:0] == SIZE_WORD) && (addr_lo != 2'b00));
        if (illegal) begin
            return FAULT_ILLEGAL;
        end else if (misalign) begin
            return FAULT_MISALIGN;
        end
        return FAULT_NONE;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
//   Purely combinational byte-lane steering for the load/store unit.
//   Store side: builds byte enables and lane-replicated write data.
//   Load side : selects the addressed byte/half lane and sign/zero-extends.
// Ports
//   funct3_i   in   3   size/signedness of the access
//   addr_lo_i  in   2   low address bits (byte offset within the word)
//   wdata_i    in   32  raw store data (rs2)
//   rdata_i    in   32  raw read word from data memory
//   mask_o     out  4   byte enables for the access
//   wdata_o    out  32  store data replicated across lanes
//   rdata_o    out  32  extracted and extended load result
// -----------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  mask_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Store mask and data. Replicating the data across all lanes lets the
    // memory pick its lane purely from the byte enables.
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        mask_o  = 4'b0000;
        wdata_o = 32'h0;
        case (funct3_i[1:0])
            SIZE_BYTE: begin
                mask_o  = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            SIZE_HALF: begin
                mask_o  = 4'b0011 << addr_lo_i;
                wdata_o = {2{wdata_i[15:0]}};
            end
            default: begin
                mask_o  = 4'b1111;
                wdata_o = wdata_i;
            end
        endcase
    end

    // Load lane extraction and extension.
    always_comb begin
        byte_lane = 8'h0;
        case (addr_lo_i)
            2'd0:    byte_lane = rdata_i[7:0];
            2'd1:    byte_lane = rdata_i[15:8];
            2'd2:    byte_lane = rdata_i[23:16];
            default: byte_lane = rdata_i[31:24];
        endcase
        half_lane = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        rdata_o = 32'h0;
        case (funct3_i)
            F3_LB:   rdata_o = {{24{byte_lane[7]}}, byte_lane};
            F3_LH:   rdata_o = {{16{half_lane[15]}}, half_lane};
            F3_LW:   rdata_o = rdata_i;
            F3_LBU:  rdata_o = {24'h0, byte_lane};
            F3_LHU:  rdata_o = {16'h0, half_lane};
            default: rdata_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Memory stage after the ALU. Takes the ALU result as effective address,
//   performs one load or store over a ready/valid data-memory port, and
//   stalls the core with o_busy until the access completes. Completion is a
//   one-cycle o_done pulse carrying o_rdata / o_fault.
// Parameters
//   WAIT_LIMIT     max cycles spent in REQ+WAIT before a timeout fault (>=1)
// Ports
//   i_clk, i_rst   clock; synchronous active-high reset
//   i_valid        memory instruction present this cycle
//   i_load/i_store instruction type
//   i_funct3       size/signedness
//   i_addr         effective address
//   i_wdata        store data
//   o_busy         stall request
//   o_done         completion pulse; o_rdata/o_fault valid with it
//   o_rdata        extended load result (0 for stores/faults)
//   o_fault        00 none, 01 misaligned, 10 illegal, 11 timeout
//   o_dmem_*       request side of the data-memory port
//   i_dmem_*       handshake/response side of the data-memory port
// -----------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic        i_load,
    input  logic        i_store,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic [1:0]  o_fault,
    output logic        o_dmem_req,
    output logic        o_dmem_wen,
    output logic [31:0] o_dmem_addr,
    output logic [3:0]  o_dmem_mask,
    output logic [31:0] o_dmem_wdata,
    input  logic        i_dmem_ready,
    input  logic        i_dmem_rvalid,
    input  logic [31:0] i_dmem_rdata
);

    // Counter must be able to hold WAIT_LIMIT itself: a load accepted on the
    // final budget cycle moves to WAIT with the count already at the limit.
    localparam int unsigned     CNT_W    = $clog2(WAIT_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

    lsu_state_e       state_q, state_d;
    lsu_fault_e       fault_q, fault_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic [31:0]      addr_q,   addr_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [31:0]      wdata_q,  wdata_d;
    logic             is_load_q, is_load_d;

    logic             start;
    lsu_fault_e       start_fault;
    logic             timeout_hit;

    logic [3:0]       align_mask;
    logic [31:0]      align_wdata;
    logic [31:0]      align_rdata;

    // Alignment always works on the captured operation, which is held stable
    // from REQ through WAIT.
    lsu_align u_align (
        .funct3_i  (funct3_q),
        .addr_lo_i (addr_q[1:0]),
        .wdata_i   (wdata_q),
        .rdata_i   (i_dmem_rdata),
        .mask_o    (align_mask),
        .wdata_o   (align_wdata),
        .rdata_o   (align_rdata)
    );

    // Reset suppresses a start in the same cycle so all outputs read 0.
    assign start       = (state_q == ST_IDLE) && i_valid && (i_load || i_store)
                      && !i_rst;
    assign start_fault = op_check(i_load, i_store, i_funct3, i_addr[1:0]);
    // Handshakes are tested before this in every state, so they win a tie.
    assign timeout_hit = (cnt_q >= CNT_LAST);

    // Next-state and capture logic.
    always_comb begin
        state_d   = state_q;
        fault_d   = fault_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        funct3_d  = funct3_q;
        wdata_d   = wdata_q;
        is_load_d = is_load_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d    = i_addr;
                    funct3_d  = i_funct3;
                    wdata_d   = i_wdata;
                    is_load_d = i_load;
                    cnt_d     = '0;
                    rdata_d   = 32'h0;
                    fault_d   = start_fault;
                    // Faulting operations never touch memory.
                    state_d   = (start_fault != FAULT_NONE) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                if (i_dmem_ready) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = is_load_q ? ST_WAIT : ST_DONE;
                end else if (timeout_hit) begin
                    fault_d = FAULT_TIMEOUT;
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            ST_WAIT: begin
                if (i_dmem_rvalid) begin
                    rdata_d = align_rdata;
                    state_d = ST_DONE;
                end else if (timeout_hit) begin
                    fault_d = FAULT_TIMEOUT;
                    rdata_d = 32'h0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: begin
                // ST_DONE: the core commits at this edge; i_valid is ignored.
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state: reset returns to IDLE from anywhere, aborting any access.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge value, independent of block order.
        if (i_rst) begin
            state_q <= ST_IDLE;
            fault_q <= FAULT_NONE;
            rdata_q <= 32'h0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: captured operands are deliberately not reset; they are always
    // written on start before being used, and outputs are gated by state.
    always_ff @(posedge i_clk) begin
        addr_q    <= addr_d;
        funct3_q  <= funct3_d;
        wdata_q   <= wdata_d;
        is_load_q <= is_load_d;
    end

    // Outputs. Memory fields are driven only while requesting so they are 0
    // in reset and idle; results are presented only in the DONE cycle.
    always_comb begin
        o_busy       = 1'b0;
        o_done       = 1'b0;
        o_rdata      = 32'h0;
        o_fault      = FAULT_NONE;
        o_dmem_req   = 1'b0;
        o_dmem_wen   = 1'b0;
        o_dmem_addr  = 32'h0;
        o_dmem_mask  = 4'b0000;
        o_dmem_wdata = 32'h0;

        if (!i_rst) begin
            o_busy = start || (state_q == ST_REQ) || (state_q == ST_WAIT);
            if (state_q == ST_REQ) begin
                o_dmem_req   = 1'b1;
                o_dmem_wen   = !is_load_q;
                o_dmem_addr  = {addr_q[31:2], 2'b00};
                o_dmem_mask  = align_mask;
                o_dmem_wdata = is_load_q ? 32'h0 : align_wdata;
            end
            if (state_q == ST_DONE) begin
                o_done  = 1'b1;
                o_rdata = rdata_q;
                o_fault = fault_q;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//   Directed bench for load_store_unit with WAIT_LIMIT = 4. Inputs change one
//   time unit after the rising edge; outputs are sampled two units after it.
// -----------------------------------------------------------------------------
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int unsigned WAIT_LIMIT = 4;

    logic        clk;
    logic        rst;
    logic        valid;
    logic        load;
    logic        store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic [1:0]  fault;
    logic        dmem_req;
    logic        dmem_wen;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_mask;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    int vectors     = 0;
    int miscompares = 0;

    load_store_unit #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_valid       (valid),
        .i_load        (load),
        .i_store       (store),
        .i_funct3      (funct3),
        .i_addr        (addr),
        .i_wdata       (wdata),
        .o_busy        (busy),
        .o_done        (done),
        .o_rdata       (rdata),
        .o_fault       (fault),
        .o_dmem_req    (dmem_req),
        .o_dmem_wen    (dmem_wen),
        .o_dmem_addr   (dmem_addr),
        .o_dmem_mask   (dmem_mask),
        .o_dmem_wdata  (dmem_wdata),
        .i_dmem_ready  (dmem_ready),
        .i_dmem_rvalid (dmem_rvalid),
        .i_dmem_rdata  (dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        valid       = 1'b0;
        load        = 1'b0;
        store       = 1'b0;
        funct3      = 3'b000;
        addr        = 32'h0;
        wdata       = 32'h0;
        dmem_ready  = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;
    endtask

    // Present an op for one IDLE cycle; busy must rise combinationally.
    task automatic start_op(input string tag, input logic ld, input logic st,
                            input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd);
        valid  = 1'b1;
        load   = ld;
        store  = st;
        funct3 = f3;
        addr   = a;
        wdata  = wd;
        #1;
        check({tag, "/busy_start"}, 32'(busy), 32'd1);
        check({tag, "/req_start"},  32'(dmem_req), 32'd0);
        tick;
        valid = 1'b0;
        load  = 1'b0;
        store = 1'b0;
    endtask

    task automatic do_store(input string tag, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] exp_mask,
                            input logic [31:0] exp_wdata);
        start_op(tag, 1'b0, 1'b1, f3, a, wd);
        dmem_ready = 1'b1;
        #1;
        check({tag, "/req"},   32'(dmem_req), 32'd1);
        check({tag, "/wen"},   32'(dmem_wen), 32'd1);
        check({tag, "/addr"},  dmem_addr, {a[31:2], 2'b00});
        check({tag, "/mask"},  32'(dmem_mask), 32'(exp_mask));
        check({tag, "/wdata"}, dmem_wdata, exp_wdata);
        tick;
        // DONE cycle: a new op offered now must be ignored.
        dmem_ready = 1'b0;
        valid      = 1'b1;
        store      = 1'b1;
        #1;
        check({tag, "/done"},  32'(done), 32'd1);
        check({tag, "/fault"}, 32'(fault), 32'd0);
        check({tag, "/rdata"}, rdata, 32'h0);
        check({tag, "/busy_done"}, 32'(busy), 32'd0);
        tick;
        valid = 1'b0;
        store = 1'b0;
        #1;
        check({tag, "/done_clr"},   32'(done), 32'd0);
        check({tag, "/no_restart"}, 32'(dmem_req), 32'd0);
    endtask

    // Load accepted in its first REQ cycle; rvalid arrives 'delay' cycles
    // after acceptance. A junk rvalid in the REQ cycle must be ignored.
    task automatic do_load(input string tag, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] word,
                           input int delay, input logic [31:0] exp_rdata);
        start_op(tag, 1'b1, 1'b0, f3, a, 32'h0);
        dmem_ready  = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = ~word;
        #1;
        check({tag, "/req"},  32'(dmem_req), 32'd1);
        check({tag, "/wen"},  32'(dmem_wen), 32'd0);
        check({tag, "/addr"}, dmem_addr, {a[31:2], 2'b00});
        tick;
        dmem_ready  = 1'b0;
        dmem_rvalid = 1'b0;
        for (int i = 1; i <= delay; i++) begin
            if (i == delay) begin
                dmem_rvalid = 1'b1;
                dmem_rdata  = word;
            end
            #1;
            check({tag, "/busy_wait"}, 32'(busy), 32'd1);
            check({tag, "/done_wait"}, 32'(done), 32'd0);
            tick;
            dmem_rvalid = 1'b0;
        end
        #1;
        check({tag, "/done"},  32'(done), 32'd1);
        check({tag, "/rdata"}, rdata, exp_rdata);
        check({tag, "/fault"}, 32'(fault), 32'd0);
        tick;
    endtask

    // Ops that fault at start: no request, done the very next cycle.
    task automatic fault_op(input string tag, input logic ld, input logic st,
                            input logic [2:0] f3, input logic [31:0] a,
                            input logic [1:0] exp_fault);
        start_op(tag, ld, st, f3, a, 32'h5555_AAAA);
        #1;
        check({tag, "/req"},   32'(dmem_req), 32'd0);
        check({tag, "/done"},  32'(done), 32'd1);
        check({tag, "/fault"}, 32'(fault), 32'(exp_fault));
        check({tag, "/rdata"}, rdata, 32'h0);
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick;
        tick;
        // Reset held with an op offered: everything must stay 0.
        valid = 1'b1;
        load  = 1'b1;
        #1;
        check("reset/busy",  32'(busy), 32'd0);
        check("reset/done",  32'(done), 32'd0);
        check("reset/req",   32'(dmem_req), 32'd0);
        check("reset/fault", 32'(fault), 32'd0);
        check("reset/rdata", rdata, 32'h0);
        check("reset/mask",  32'(dmem_mask), 32'd0);
        tick;
        rst   = 1'b0;
        valid = 1'b0;
        load  = 1'b0;
        tick;

        // Stores
        do_store("sw", F3_SW, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
        do_store("sh", F3_SH, 32'h0000_0102, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD);
        do_store("sb", F3_SB, 32'h0000_0101, 32'h1234_ABEF, 4'b0010, 32'hEFEF_EFEF);

        // Loads; delay 3 lands rvalid on the last budget cycle (handshake wins)
        do_load("lb",     F3_LB,  32'h0000_0103, 32'h8012_3456, 3, 32'hFFFF_FF80);
        do_load("lbu",    F3_LBU, 32'h0000_0103, 32'h8012_3456, 3, 32'h0000_0080);
        do_load("lh_hi",  F3_LH,  32'h0000_0102, 32'h8001_7FFF, 1, 32'hFFFF_8001);
        do_load("lhu_lo", F3_LHU, 32'h0000_0100, 32'h8001_F00F, 2, 32'h0000_F00F);
        do_load("lw",     F3_LW,  32'h0000_0104, 32'h1234_5678, 1, 32'h1234_5678);
        do_load("lb1",    F3_LB,  32'h0000_0101, 32'h0000_7F00, 1, 32'h0000_007F);

        // Start-time faults
        fault_op("lh_mis",    1'b1, 1'b0, F3_LH,  32'h0000_0101, 2'b01);
        fault_op("sw_mis",    1'b0, 1'b1, F3_SW,  32'h0000_0102, 2'b01);
        fault_op("ld_and_st", 1'b1, 1'b1, F3_LW,  32'h0000_0100, 2'b10);
        fault_op("ld_f3_011", 1'b1, 1'b0, 3'b011, 32'h0000_0100, 2'b10);
        fault_op("st_f3_100", 1'b0, 1'b1, 3'b100, 32'h0000_0100, 2'b10);
        fault_op("ill_wins",  1'b1, 1'b0, 3'b110, 32'h0000_0101, 2'b10);

        // Timeout in REQ: ready never comes, req held for exactly 4 cycles.
        start_op("to_req", 1'b0, 1'b1, F3_SW, 32'h0000_0200, 32'h0BAD_F00D);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("to_req/req_held", 32'(dmem_req), 32'd1);
            tick;
        end
        #1;
        check("to_req/req_drop", 32'(dmem_req), 32'd0);
        check("to_req/done",     32'(done), 32'd1);
        check("to_req/fault",    32'(fault), 32'd3);
        check("to_req/rdata",    rdata, 32'h0);
        tick;

        // Timeout in WAIT: accepted at once, rvalid never comes.
        start_op("to_wait", 1'b1, 1'b0, F3_LW, 32'h0000_0300, 32'h0);
        dmem_ready = 1'b1;
        tick;
        dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("to_wait/busy", 32'(busy), 32'd1);
            tick;
        end
        #1;
        check("to_wait/done",  32'(done), 32'd1);
        check("to_wait/fault", 32'(fault), 32'd3);
        check("to_wait/rdata", rdata, 32'h0);
        tick;

        // Reset during WAIT, then a stale rvalid.
        start_op("rst_wait", 1'b1, 1'b0, F3_LW, 32'h0000_0100, 32'h0);
        dmem_ready = 1'b1;
        tick;
        dmem_ready = 1'b0;
        #1;
        check("rst_wait/busy_wait", 32'(busy), 32'd1);
        rst = 1'b1;
        tick;
        rst         = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hCAFE_F00D;
        #1;
        check("rst_wait/busy", 32'(busy), 32'd0);
        check("rst_wait/done", 32'(done), 32'd0);
        check("rst_wait/req",  32'(dmem_req), 32'd0);
        tick;
        dmem_rvalid = 1'b0;
        #1;
        check("rst_wait/done_after", 32'(done), 32'd0);
        check("rst_wait/busy_after", 32'(busy), 32'd0);
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
